// File: rtl/pc_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : pc_unit                                                    |
// | Description : Program counter with branch/jump/call/return sequencing,   |
// |               a bounded return-address stack and an IDLE/RUN/DONE FSM.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_unit #(
  parameter int PC_W    = 10,
  parameter int STACK_D = 4
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [PC_W-1:0]   Start_addr,
  input  logic              Halt,
  input  logic              Stall,
  input  logic              Branch_rel,
  input  logic              Branch_taken,
  input  logic              Jump_abs,
  input  logic              Call,
  input  logic              Ret,
  input  logic signed [7:0] Target,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
  output logic              Done,
  output logic              Stack_err
);

  localparam int c_SP_W  = $clog2(STACK_D + 1);
  localparam int c_IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt;
  logic [c_SP_W-1:0]   r_sp, w_sp_nxt;
  logic                r_err, w_err_nxt;
  logic                r_running, r_done;
  logic                w_push;
  logic [PC_W-1:0]     r_stack [0:STACK_D-1];

  logic [PC_W-1:0]     w_tgt_sext, w_tgt_zext, w_pc_inc;
  logic [c_SP_W-1:0]   w_sp_m1;
  logic [c_IDX_W-1:0]  w_push_idx, w_pop_idx;

  assign w_tgt_sext = PC_W'(Target);
  assign w_tgt_zext = PC_W'($unsigned(Target));
  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_sp_m1    = r_sp - c_SP_W'(1);
  assign w_push_idx = r_sp[c_IDX_W-1:0];
  assign w_pop_idx  = w_sp_m1[c_IDX_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = Start_addr;
          w_sp_nxt    = '0;
        end
      end
      S_RUN: begin
        if (Stall) begin
          // everything frozen
        end else if (Halt) begin
          w_state_nxt = S_DONE;
        end else if (Ret) begin
          if (r_sp == '0) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_pc_nxt = r_stack[w_pop_idx];
            w_sp_nxt = w_sp_m1;
          end
        end else if (Call) begin
          if (r_sp == c_SP_W'(STACK_D)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = r_pc + w_tgt_sext;
            w_sp_nxt = r_sp + c_SP_W'(1);
          end
        end else if (Jump_abs) begin
          w_pc_nxt = w_tgt_zext;
        end else if (Branch_rel && Branch_taken) begin
          w_pc_nxt = r_pc + w_tgt_sext;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      S_DONE: begin
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = Start_addr;
          w_sp_nxt    = '0;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_sp      <= '0;
      r_err     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_sp      <= w_sp_nxt;
      r_err     <= w_err_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  // Stack storage needs no reset: the pointer alone defines which entries are live.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign PC        = r_pc;
  assign Running   = r_running;
  assign Done      = r_done;
  assign Stack_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_pc_unit                                                 |
// | Description : Self-checking bench for pc_unit against a queue-based model|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pc_unit;

  localparam int PC_W    = 10;
  localparam int STACK_D = 4;
  localparam int c_MOD   = 1 << PC_W;

  logic              CLK;
  logic              Reset_n;
  logic              Start;
  logic [PC_W-1:0]   Start_addr;
  logic              Halt, Stall, Branch_rel, Branch_taken, Jump_abs, Call, Ret;
  logic signed [7:0] Target;
  logic [PC_W-1:0]   PC;
  logic              Running, Done, Stack_err;

  pc_unit #(.PC_W(PC_W), .STACK_D(STACK_D)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Start_addr(Start_addr),
    .Halt(Halt), .Stall(Stall), .Branch_rel(Branch_rel), .Branch_taken(Branch_taken),
    .Jump_abs(Jump_abs), .Call(Call), .Ret(Ret), .Target(Target),
    .PC(PC), .Running(Running), .Done(Done), .Stack_err(Stack_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: 0 idle, 1 run, 2 done; return stack as a queue
  int m_state;
  int m_pc;
  int m_stack[$];
  bit m_err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},      {22'd0, PC},        m_pc);
    chk({tag, ".running"}, {31'd0, Running},   (m_state == 1) ? 1 : 0);
    chk({tag, ".done"},    {31'd0, Done},      (m_state == 2) ? 1 : 0);
    chk({tag, ".err"},     {31'd0, Stack_err}, {31'd0, m_err});
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_err   = 0;
    m_stack.delete();
  endtask

  task automatic model_step();
    int off;
    off = int'(Target);
    if (m_state == 0 || m_state == 2) begin
      if (Start) begin
        m_state = 1;
        m_pc    = int'(Start_addr);
        m_stack.delete();
        m_err   = 0;
      end
    end else if (Stall) begin
    end else if (Halt) begin
      m_state = 2;
    end else if (Ret) begin
      if (m_stack.size() == 0) begin
        m_err = 1; m_state = 2;
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else if (Call) begin
      if (m_stack.size() == STACK_D) begin
        m_err = 1; m_state = 2;
      end else begin
        m_stack.push_back((m_pc + 1) % c_MOD);
        m_pc = (m_pc + off + c_MOD) % c_MOD;
      end
    end else if (Jump_abs) begin
      m_pc = off & 8'hFF;
    end else if (Branch_rel && Branch_taken) begin
      m_pc = (m_pc + off + c_MOD) % c_MOD;
    end else begin
      m_pc = (m_pc + 1) % c_MOD;
    end
  endtask

  task automatic clear_inputs();
    Start = 0; Start_addr = '0; Halt = 0; Stall = 0; Branch_rel = 0;
    Branch_taken = 0; Jump_abs = 0; Call = 0; Ret = 0; Target = '0;
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    model_step();
    #1;
    check_all(tag);
    clear_inputs();
  endtask

  task automatic expect_pc(input string tag, input int v);
    chk({tag, ".const_pc"}, {22'd0, PC}, v);
  endtask

  task automatic restart(input int addr);
    Halt = 1; tick("restart_halt");
    Start = 1; Start_addr = PC_W'(addr); tick("restart_start");
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 Reset_n = 0;
    #1 model_reset();
    check_all(tag);
    chk({tag, ".const_pc0"}, {22'd0, PC}, 0);
    #1 Reset_n = 1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    Reset_n = 0;
    repeat (2) @(posedge CLK);
    #1 check_all("reset");
    @(negedge CLK) Reset_n = 1;
    @(posedge CLK); #1;

    // Start and plain increments
    Start = 1; Start_addr = 10'd5; tick("start5"); expect_pc("start5", 5);
    for (int i = 0; i < 3; i++) begin
      tick("inc"); expect_pc("inc", 6 + i);
    end
    Start = 1; Start_addr = 10'd100; tick("start_ignored"); expect_pc("start_ignored", 9);

    // Relative branches
    restart(20); Branch_rel = 1; Branch_taken = 1; Target = -8'sd11; tick("br_taken");
    expect_pc("br_taken", 9);
    restart(20); Branch_rel = 1; Branch_taken = 0; Target = -8'sd11; tick("br_not");
    expect_pc("br_not", 21);

    // Absolute jump and wrap
    restart(30); Jump_abs = 1; Target = 8'shEE; tick("jump"); expect_pc("jump", 238);
    restart(1023); tick("wrap"); expect_pc("wrap", 0);

    // Call / return / underflow
    restart(40); Call = 1; Target = 8'sd7; tick("call"); expect_pc("call", 47);
    Ret = 1; tick("ret"); expect_pc("ret", 41);
    Ret = 1; tick("ret_underflow"); expect_pc("ret_underflow", 41);
    chk("underflow.err", {31'd0, Stack_err}, 1);
    chk("underflow.done", {31'd0, Done}, 1);

    // Overflow on the fifth call, then recovery
    Start = 1; Start_addr = '0; tick("restart0");
    for (int i = 0; i < 5; i++) begin
      Call = 1; Target = 8'sd1; tick("call_chain");
    end
    chk("overflow.err", {31'd0, Stack_err}, 1);
    chk("overflow.done", {31'd0, Done}, 1);
    expect_pc("overflow", 4);
    Start = 1; Start_addr = '0; tick("recover");
    chk("recover.err", {31'd0, Stack_err}, 0);
    chk("recover.run", {31'd0, Running}, 1);

    // Stall dominates Halt, then async reset
    restart(77);
    for (int i = 0; i < 2; i++) begin
      Stall = 1; Halt = 1; tick("stall_halt"); expect_pc("stall_halt", 77);
    end
    Halt = 1; tick("halt"); chk("halt.done", {31'd0, Done}, 1);
    async_reset_pulse("async_reset");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      Start        = (m_state == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      Start_addr   = PC_W'($urandom);
      Halt         = ($urandom_range(0, 29) == 0);
      Stall        = ($urandom_range(0, 5) == 0);
      Ret          = ($urandom_range(0, 5) == 0);
      Call         = ($urandom_range(0, 5) == 0);
      Jump_abs     = ($urandom_range(0, 11) == 0);
      Branch_rel   = ($urandom_range(0, 3) == 0);
      Branch_taken = 1'($urandom);
      Target       = 8'($urandom);
      tick("rand");
      if ($urandom_range(0, 99) == 0) async_reset_pulse("rand_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter width in bits.
REQ-002 SHALL have parameter STACK_D, default 4, return-address stack depth in entries.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  begin execution at Start_addr.
REQ-006 SHALL have port Start_addr  input  PC_W  first instruction address.
REQ-007 SHALL have port Halt  input  1  decoded halt instruction.
REQ-008 SHALL have port Stall  input  1  freeze PC this cycle.
REQ-009 SHALL have port Branch_rel  input  1  relative-branch instruction present.
REQ-010 SHALL have port Branch_taken  input  1  branch condition true.
REQ-011 SHALL have port Jump_abs  input  1  absolute-jump instruction present.
REQ-012 SHALL have port Call  input  1  relative call; push return address.
REQ-013 SHALL have port Ret  input  1  return; pop return address.
REQ-014 SHALL have port Target  input  8 signed  offset/address from the PC lookup table.
REQ-015 SHALL have port PC  output  PC_W  current instruction address.
REQ-016 SHALL have port Running  output  1  high in RUN state.
REQ-017 SHALL have port Done  output  1  high in DONE state.
REQ-018 SHALL have port Stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE; Running/Done are registered decodes of state.
REQ-020 IDLE: Start=1 -> RUN, PC<=Start_addr, stack emptied; otherwise hold.
REQ-021 RUN: one PC update per cycle chosen by fixed priority: Stall > Halt > Ret > Call > Jump_abs > (Branch_rel & Branch_taken) > increment.
REQ-022 Stall: PC, stack, state unchanged; all other control inputs ignored.
REQ-023 Halt: state -> DONE, PC unchanged.
REQ-024 Increment: PC <= PC+1 modulo 2^PC_W (wraps from all-ones to 0).
REQ-025 Relative branch taken: PC <= PC + sign-extend(Target) modulo 2^PC_W; Branch_rel with Branch_taken=0 behaves as increment.
REQ-026 Jump_abs: PC <= zero-extend(Target as unsigned 8 bits); upper PC bits cleared.
REQ-027 Call: push PC+1 (mod 2^PC_W), then PC <= PC + sign-extend(Target) in the same cycle.
REQ-028 Ret: PC <= top-of-stack, pop, same cycle; new PC visible the cycle after.
REQ-029 Call with stack holding STACK_D entries: no push, PC unchanged, Stack_err<=1, state -> DONE.
REQ-030 Ret with stack empty: PC unchanged, Stack_err<=1, state -> DONE.
REQ-031 Start ignored in RUN.
REQ-032 DONE: PC held; Start=1 -> RUN, PC<=Start_addr, stack emptied, Stack_err<=0.
REQ-033 Latency: every control input sampled at edge N affects PC at edge N, visible after N.

Reset
REQ-034 Reset_n=0 SHALL immediately force state IDLE, PC=0, stack empty, Running=0, Done=0, Stack_err=0, independent of CLK.
REQ-035 Reset asserted mid-RUN SHALL discard pending control and stack contents; Start required after release.

Verification
REQ-036 Reset, Start, Start_addr=5, 3 idle cycles -> PC 5,6,7,8; Running=1.
REQ-037 PC=20, Branch_rel=1, Branch_taken=1, Target=-11 -> PC=9; Branch_taken=0 instead -> PC=21.
REQ-038 PC=30, Jump_abs=1, Target=-18 (0xEE) -> PC=238; PC=1023 increment -> PC=0.
REQ-039 PC=40 Call Target=7 -> PC=47, stack top 41; next cycle Ret -> PC=41; Ret again -> Stack_err=1, Done=1, PC=41.
REQ-040 Five consecutive Calls (STACK_D=4) -> fifth sets Stack_err=1, Done=1; then Start, Start_addr=0 -> PC=0, Stack_err=0, Running=1.
REQ-041 Stall and Halt together for 2 cycles -> PC frozen, Running=1; Stall drops -> Done=1 next cycle; Reset_n pulse low mid-cycle -> PC=0, Done=0 before next edge.
